// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Brief  : Shared types and defaults for the convolver sequencer
// Rev    : 1.0  initial release
// ============================================================================
package conv_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_IMG_WIDTH   = 28;
  localparam int DEF_IMG_HEIGHT  = 28;

  // Number of full KxK windows (out_valid pulses) in a W x H frame
  function automatic int out_valid_count(input int k, input int w, input int h);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module : raster_counter
// Brief  : Raster-order pixel position tracker. Holds the coordinates of the
//          last accepted pixel and flags the pixel about to be accepted as
//          last-in-frame and/or completing a full KxK window.
// Rev    : 1.0  initial release
// ============================================================================
module raster_counter #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_last,
  output logic             o_win
);

  localparam logic [CNT_W-1:0] c_last_col = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_last_row = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] c_km1      = CNT_W'(KERNEL_SIZE - 1);

  // Position of the next pixel to be accepted; o_col/o_row lag by one pixel
  logic [CNT_W-1:0] r_ncol;
  logic [CNT_W-1:0] r_nrow;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  // Flags describe the pixel currently offered for acceptance
  assign o_last = (r_ncol == c_last_col) && (r_nrow == c_last_row);
  assign o_win  = (r_ncol >= c_km1) && (r_nrow >= c_km1);
  assign o_col  = r_col;
  assign o_row  = r_row;

  // Advance the raster position on each accepted pixel; clear wins over enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ncol <= '0;
      r_nrow <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (i_clear) begin
      r_ncol <= '0;
      r_nrow <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (i_en) begin
      r_col <= r_ncol;
      r_row <= r_nrow;
      if (r_ncol == c_last_col) begin
        r_ncol <= '0;
        r_nrow <= r_nrow + 1'b1;
      end else begin
        r_ncol <= r_ncol + 1'b1;
      end
    end
  end

endmodule : raster_counter
`default_nettype wire

// File: rtl/convolver_sequencer.sv
`default_nettype none
// ============================================================================
// Module : convolver_sequencer
// Brief  : Control FSM for the convolver datapath: loads K*K weights, then
//          streams a W x H frame and flags cycles carrying a full-window MAC.
// Rev    : 1.0  initial release
// ============================================================================
module convolver_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int WADDR_W     = $clog2(KERNEL_SIZE * KERNEL_SIZE),
  parameter int CNT_W       = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               reuse_weights,
  input  logic               abort,
  input  logic               weight_valid,
  output logic               weight_ready,
  output logic               write_weights,
  output logic [WADDR_W-1:0] weight_addr,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  output logic               kernel_shift,
  output logic               out_valid,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   row,
  output logic               busy,
  output logic               done
);

  localparam logic [WADDR_W-1:0] c_last_waddr = WADDR_W'(KERNEL_SIZE * KERNEL_SIZE - 1);

  state_t             r_state;
  logic [WADDR_W-1:0] r_wcnt;
  logic               r_out_valid;

  logic w_pix_acc;
  logic w_abort;
  logic w_clear;
  logic w_last;
  logic w_win;

  // Strobes decode from registered state so data presented under abort is still taken
  assign w_pix_acc     = (r_state == STREAM) && pixel_valid;
  assign w_abort       = abort && (r_state != IDLE);
  assign w_clear       = w_abort || (r_state == DONE);

  assign weight_ready  = (r_state == LOAD_W);
  assign write_weights = (r_state == LOAD_W) && weight_valid;
  assign weight_addr   = r_wcnt;
  assign pixel_ready   = (r_state == STREAM);
  assign kernel_shift  = w_pix_acc;
  assign out_valid     = r_out_valid;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);

  raster_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_WIDTH   (IMG_WIDTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .CNT_W       (CNT_W)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_en    (w_pix_acc),
    .o_col   (col),
    .o_row   (row),
    .o_last  (w_last),
    .o_win   (w_win)
  );

  // Main sequencer: state, weight address counter and the registered window strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_pix_acc && w_win;
      if (w_abort) begin
        r_state <= IDLE;
        r_wcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= reuse_weights ? STREAM : LOAD_W;
            end
          end
          LOAD_W: begin
            if (weight_valid) begin
              if (r_wcnt == c_last_waddr) begin
                r_wcnt  <= '0;
                r_state <= STREAM;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end
          end
          STREAM: begin
            if (w_pix_acc && w_last) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_wcnt  <= '0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule : convolver_sequencer
`default_nettype wire

// File: doc/convolver_sequencer.md
Name: convolver_sequencer

Overview:
Parametrised control sequencer for the convolver datapath; replaces the fixed 2-bit decode of shift/weight-write strobes with a clocked FSM.
- Loads K*K kernel weights, then streams an IMG_WIDTH x IMG_HEIGHT image through the line-buffer/shift window.
- Emits window-valid strobes only where a full KxK window exists.
- Sits between the host/DMA handshake and the convolver datapath (weight RAM, shift registers, MAC array).

Parameters:
KERNEL_SIZE, 3, kernel edge K (>=2)
IMG_WIDTH, 28, pixels per row W (>=K)
IMG_HEIGHT, 28, rows per frame H (>=K)
WADDR_W, $clog2(K*K), weight address width
CNT_W, $clog2(max(W,H)), row/column counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin frame; sampled only in IDLE
reuse_weights  in  1  sampled with start; 1 = skip weight load
abort  in  1  synchronous return to IDLE
weight_valid  in  1  weight word present on datapath bus
weight_ready  out  1  sequencer accepting weights
write_weights  out  1  weight RAM write enable
weight_addr  out  WADDR_W  weight RAM write address
pixel_valid  in  1  pixel present on datapath bus
pixel_ready  out  1  sequencer accepting pixels
kernel_shift  out  1  advance window/line buffers one pixel
out_valid  out  1  MAC result for a full window is valid
col  out  CNT_W  column of last accepted pixel
row  out  CNT_W  row of last accepted pixel
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters 0; every output 0. Leaving reset is synchronous to clk.
- States: IDLE, LOAD_W, STREAM, DONE; 2-bit encoding lives in the package.
- IDLE:
  - start=1 and reuse_weights=0 -> LOAD_W.
  - start=1 and reuse_weights=1 -> STREAM.
  - Stays in IDLE otherwise; start is ignored in every other state.
- LOAD_W:
  - weight_ready=1.
  - write_weights = weight_valid (combinational from registered state); weight_addr = wcnt.
  - wcnt increments on each accepted weight.
  - Accepting the weight at wcnt=K*K-1 -> STREAM next cycle; wcnt clears.
  - Gaps in weight_valid only stall; no timeout.
- STREAM:
  - pixel_ready=1; kernel_shift = pixel_valid (same cycle as acceptance).
  - On each accepted pixel, col/row update to that pixel's coordinates. Raster order: col 0..W-1, then wrap to 0 with row+1.
  - out_valid is registered: high for exactly one cycle, the cycle after accepting a pixel with row>=K-1 and col>=K-1.
  - Accepting pixel (H-1, W-1) -> DONE.
- DONE:
  - done=1 for one cycle; the final out_valid coincides with this cycle.
  - Counters clear; -> IDLE.
- abort=1 in any non-IDLE state:
  - -> IDLE next cycle; counters clear; no done pulse.
  - Any weight/pixel presented in that same cycle is still accepted (strobes asserted). Abort has priority over state advance.
- Totals per frame: out_valid pulses = (H-K+1)*(W-K+1); accepted pixels = W*H.
- Weights persist in the datapath RAM; reuse_weights depends on that RAM, and the sequencer holds no weight state.

Decomposition:
- Package conv_pkg:
  - state enum (IDLE, LOAD_W, STREAM, DONE);
  - default KERNEL_SIZE/IMG_WIDTH/IMG_HEIGHT constants;
  - a function computing the out_valid count for benches.
- One sub-module, raster_counter: col/row counters with enable, wrap at W-1, last-pixel flag and window-valid flag (row>=K-1 && col>=K-1).

Test Plan:
1. K=3, W=H=5, start with reuse_weights=0, 9 back-to-back weights -> write_weights on 9 cycles with weight_addr 0..8; STREAM entered the cycle after addr 8.
2. Continue with 25 back-to-back pixels -> 25 kernel_shift pulses; 9 out_valid pulses; first out_valid the cycle after pixel 13 (row 2, col 2); done one cycle after pixel 25; busy low the following cycle.
3. start with reuse_weights=1 -> no write_weights, pixel_ready high the next cycle; frame yields 9 out_valid.
4. pixel_valid toggling 1,0,1,0 through the frame -> kernel_shift only on valid cycles; out_valid count still 9; col/row hold during gaps.
5. abort in STREAM after pixel 10 -> IDLE next cycle, no done; a new start frame produces correct first out_valid after 13 pixels.
6. reset driven low mid-LOAD_W at weight_addr=4, asynchronously between clock edges -> all outputs 0 immediately; after release, start restarts from weight_addr 0.
